// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port, word-addressed data memory between the pipeline
//   MEM stage (port 0) and a secondary master (port 1). At most one access is
//   granted per cycle, with round-robin priority when both ports request.
//   Read data is routed back to its owner RD_LAT cycles after the strobe.
//   Misaligned or out-of-range accesses are flagged on errN.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN         port N request (byte address)
//   gntN                          port N granted this cycle (combinational)
//   rvalidN/rdataN/errN           port N response
//   stall_m                       port 0 is waiting (req0 & ~gnt0)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory interface
module dmem_port_arbiter #(
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [31:0]   addr0,
  input  logic [31:0]   wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [31:0]   rdata0,
  output logic          err0,
  output logic          stall_m,
  input  logic          req1,
  input  logic          we1,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [31:0]   rdata1,
  output logic          err1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef struct packed {
    logic valid;
    logic owner;
    logic fault;
  } rsp_t;

  logic                r_last_gnt;
  rsp_t [RD_LAT-1:0]   r_pipe;
  logic                r_werr0;
  logic                r_werr1;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_fault0;
  logic                w_fault1;
  logic                w_sel_we;
  logic                w_sel_fault;
  logic [AW-1:0]       w_sel_waddr;
  logic [31:0]         w_sel_wdata;
  rsp_t                w_tail;
  logic                w_rsp0;
  logic                w_rsp1;

  assign w_fault0 = (addr0[1:0] != 2'b00) || (addr0[31:AW+2] != '0);
  assign w_fault1 = (addr1[1:0] != 2'b00) || (addr1[31:AW+2] != '0);

  // r_last_gnt names the port granted most recently; the other port wins a tie.
  assign w_gnt0 = ~reset & req0 & (~req1 | r_last_gnt);
  assign w_gnt1 = ~reset & req1 & (~req0 | ~r_last_gnt);

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_fault = 1'b0;
    w_sel_waddr = '0;
    w_sel_wdata = '0;
    if (w_gnt0) begin
      w_sel_we    = we0;
      w_sel_fault = w_fault0;
      w_sel_waddr = addr0[AW+1:2];
      w_sel_wdata = wdata0;
    end else if (w_gnt1) begin
      w_sel_we    = we1;
      w_sel_fault = w_fault1;
      w_sel_waddr = addr1[AW+1:2];
      w_sel_wdata = wdata1;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign stall_m   = ~reset & req0 & ~w_gnt0;
  assign mem_en    = w_gnt0 | w_gnt1;
  // A faulting read still strobes the memory; its data is discarded at the tail.
  assign mem_we    = mem_en & w_sel_we & ~w_sel_fault;
  assign mem_addr  = w_sel_waddr;
  assign mem_wdata = w_sel_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= 1'b1;
      r_pipe     <= '0;
      r_werr0    <= 1'b0;
      r_werr1    <= 1'b0;
    end else begin
      if (mem_en) begin
        r_last_gnt <= w_gnt1;
      end
      r_pipe[0].valid <= mem_en & ~w_sel_we;
      r_pipe[0].owner <= w_gnt1;
      r_pipe[0].fault <= w_sel_fault;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_werr0 <= w_gnt0 & we0 & w_fault0;
      r_werr1 <= w_gnt1 & we1 & w_fault1;
    end
  end

  // Responses are masked while reset is high so reads in flight when reset
  // arrives never surface, even in the cycle before the pipeline is cleared.
  assign w_tail  = r_pipe[RD_LAT-1];
  assign w_rsp0  = ~reset & w_tail.valid & ~w_tail.owner;
  assign w_rsp1  = ~reset & w_tail.valid &  w_tail.owner;

  assign rvalid0 = w_rsp0;
  assign rvalid1 = w_rsp1;
  assign rdata0  = (w_rsp0 & ~w_tail.fault) ? mem_rdata : '0;
  assign rdata1  = (w_rsp1 & ~w_tail.fault) ? mem_rdata : '0;
  assign err0    = (w_rsp0 & w_tail.fault) | (~reset & r_werr0);
  assign err1    = (w_rsp1 & w_tail.fault) | (~reset & r_werr1);

endmodule
